// File: rtl/operand_scatter.sv
`default_nettype none
// ============================================================================
// Module   : operand_scatter
// Purpose  : Scatters a stream of signed operand words across N_PE lane
//            registers, then holds the frame until the PE array launches it.
//            Optional macro SCATTER_SKID_EN adds a one-entry skid register.
// Revision : 1.0 - initial release
// ============================================================================
module operand_scatter #(
    parameter int N_PE        = 32,
    parameter int WID_PE_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scatter_enable,
    input  logic                          in_valid,
    input  logic signed [WID_PE_BITS-1:0] in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic signed [WID_PE_BITS-1:0] pe_operand [N_PE],
    output logic        [N_PE-1:0]        mac_enable,
    output logic                          launch_valid,
    input  logic                          launch_ready,
    output logic        [$clog2(N_PE):0]  lane_count
);

    localparam int c_idx_w = $clog2(N_PE);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(N_PE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_wr_idx;
    logic [c_idx_w-1:0]   w_lane;
    logic                 w_accept;
    logic                 w_launch;
    logic                 w_term;

`ifdef SCATTER_SKID_EN
    logic                          r_skid_full;
    logic signed [WID_PE_BITS-1:0] r_skid_data;
    logic                          r_skid_last;
    logic                          w_load_valid;
    logic signed [WID_PE_BITS-1:0] w_load_data;
    logic                          w_load_last;

    assign in_ready     = (r_state != ST_HOLD) || !r_skid_full;
    // Word that lands in lane 0 when a launch completes: skid contents first,
    // otherwise a word arriving on the launch edge itself.
    assign w_load_valid = r_skid_full || w_accept;
    assign w_load_data  = r_skid_full ? r_skid_data : in_data;
    assign w_load_last  = r_skid_full ? r_skid_last : in_last;
`else
    assign in_ready     = (r_state != ST_HOLD);
`endif

    assign launch_valid = (r_state == ST_HOLD);
    assign w_accept     = in_valid && in_ready && scatter_enable;
    assign w_launch     = launch_valid && launch_ready && scatter_enable;
    assign w_term       = in_last || (r_wr_idx == c_last_idx);
    assign w_lane       = r_wr_idx[c_idx_w-1:0];
    assign lane_count   = r_wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    w_state_nxt = w_term ? ST_HOLD : ST_FILL;
                end
            end
            ST_HOLD: begin
                if (w_launch) begin
`ifdef SCATTER_SKID_EN
                    if (w_load_valid) begin
                        w_state_nxt = w_load_last ? ST_HOLD : ST_FILL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PE; i++) begin
                pe_operand[i] <= '0;
            end
            mac_enable <= '0;
            r_wr_idx   <= '0;
`ifdef SCATTER_SKID_EN
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
`endif
        end else if (w_launch) begin
            for (int i = 0; i < N_PE; i++) begin
                pe_operand[i] <= '0;
            end
            mac_enable <= '0;
            r_wr_idx   <= '0;
`ifdef SCATTER_SKID_EN
            if (w_load_valid) begin
                pe_operand[0] <= w_load_data;
                mac_enable[0] <= 1'b1;
                r_wr_idx      <= c_cnt_w'(1);
            end
            r_skid_full <= 1'b0;
`endif
        end else if (w_accept) begin
            if (r_state != ST_HOLD) begin
                pe_operand[w_lane] <= in_data;
                mac_enable[w_lane] <= 1'b1;
                r_wr_idx           <= r_wr_idx + c_cnt_w'(1);
            end
`ifdef SCATTER_SKID_EN
            else begin
                r_skid_full <= 1'b1;
                r_skid_data <= in_data;
                r_skid_last <= in_last;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/operand_scatter.md
OPERAND_SCATTER -- requirements
Module: operand_scatter

Interface
REQ-001 Parameter N_PE, 32 (`N_PE from header.vh), number of PE lanes; power of 2, at least 2.
REQ-002 Parameter WID_PE_BITS, 16 (`WID_PE_BITS from header.vh), operand width in bits, signed.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port scatter_enable  input  1  global advance qualifier; 0 freezes all state.
REQ-006 Port in_valid  input  1  upstream operand word valid.
REQ-007 Port in_data  input  WID_PE_BITS  signed operand word.
REQ-008 Port in_last  input  1  marks the final word of a short frame.
REQ-009 Port in_ready  output  1  block can accept a word this cycle.
REQ-010 Port pe_operand  output  WID_PE_BITS x N_PE (unpacked)  per-lane registered operand.
REQ-011 Port mac_enable  output  N_PE  per-lane valid mask; bit i set when lane i holds a frame word.
REQ-012 Port launch_valid  output  1  frame complete; pe_operand and mac_enable are stable.
REQ-013 Port launch_ready  input  1  PE array consumes the frame.
REQ-014 Port lane_count  output  $clog2(N_PE)+1  number of filled lanes in the current frame.

Function
REQ-015 The block shall implement the FSM IDLE -> FILL -> HOLD -> IDLE, with states held when scatter_enable=0.
REQ-016 A word is accepted when in_valid && in_ready && scatter_enable are all high.
REQ-017 in_ready shall be 1 in IDLE and FILL, and 0 in HOLD (unless SCATTER_SKID_EN is defined).
REQ-018 An accepted word shall be written to pe_operand[wr_idx] and set mac_enable[wr_idx]; wr_idx then increments; lane_count = wr_idx.
REQ-019 On the first accepted word the FSM shall go IDLE -> FILL; if that word has in_last=1 or N_PE=1, it shall go directly to HOLD.
REQ-020 In FILL, the FSM shall go to HOLD on the accepted word with wr_idx=N_PE-1 or with in_last=1, whichever comes first.
REQ-021 launch_valid shall be 1 exactly while in HOLD, asserting the cycle after the terminating word is written (latency 1 cycle).
REQ-022 In HOLD, launch_valid && launch_ready && scatter_enable shall complete the launch; on that edge all pe_operand lanes clear to 0, mac_enable to 0, wr_idx to 0, and the FSM goes to IDLE.
REQ-023 While launch_valid=1, pe_operand, mac_enable and lane_count shall not change.
REQ-024 Lanes not written in a short frame shall read 0 with mac_enable=0.
REQ-025 If in_last=1 and wr_idx=N_PE-1 on the same word, the block shall take a single transition to HOLD with lane_count=N_PE.
REQ-026 The block shall perform no arithmetic; values pass through bit-exact, with sign preserved.

Reset
REQ-027 While rst=1, the FSM shall be IDLE, wr_idx=0, every pe_operand lane=0, mac_enable=0, launch_valid=0 and lane_count=0; in_ready is 1 immediately after release.
REQ-028 Reset asserted mid-FILL or mid-HOLD shall discard the partial frame without emitting a launch.

Configuration
REQ-029 With macro SCATTER_SKID_EN defined, a one-entry skid register shall keep in_ready=1 in HOLD while the skid is empty.
- A word accepted in HOLD is stored in the skid.
- On launch completion the skid word is written to lane 0, with wr_idx=1 and the FSM in FILL, or HOLD if that word had in_last=1.
- in_ready shall be 0 while the skid is full.
REQ-030 With SCATTER_SKID_EN undefined, there is no skid register, and in_ready=0 throughout HOLD.

Verification
REQ-031 Full frame: 32 back-to-back words 1..32 with launch_ready=0.
- launch_valid=1 from the cycle after word 32.
- pe_operand[i]=i+1, mac_enable=32'hFFFFFFFF, lane_count=32.
REQ-032 Short frame: words -5, 7, 9 with in_last on 9.
- lanes 0..2 = -5, 7, 9; lanes 3..31 = 0.
- mac_enable=32'h7; lane_count=3.
REQ-033 Backpressure: hold launch_ready=0 for 10 cycles, then pulse it.
- Outputs are stable throughout; in_ready=0 throughout (skid off).
- The cycle after the pulse: mac_enable=0, in_ready=1.
REQ-034 Freeze: drop scatter_enable at word 16 for 5 cycles while in_valid stays high.
- No words are accepted and lane_count stays 16.
- Resuming completes the frame normally.
REQ-035 Reset mid-FILL after 8 words.
- All outputs are 0 and launch_valid never asserts.
- The next frame of 32 words fills lanes from 0.
REQ-036 With SCATTER_SKID_EN defined, send 33 words with launch_ready pulsed after the first frame.
- Word 33 is accepted during HOLD.
- After launch, lane 0 = word 33, lane_count=1, FSM in FILL.
